// File: rtl/snes_joypad.sv
// SNES controller-side responder: latches a 12-button pad on JOY_STRB and shifts it out on JOY_CLK.
// Define SNES_JOYPAD_TURBO_EN to enable per-button autofire toggled by latch count.
module snes_joypad #(
   parameter int SYNC_STAGES  = 0,
   parameter int TURBO_PERIOD = 4
) (
   input  logic        MCLK,
   input  logic        RST_N,
   input  logic        JOY_STRB,
   input  logic        JOY_CLK,
   input  logic [11:0] BUTTONS,
   input  logic [11:0] TURBO_MASK,
   output logic [1:0]  JOY_DI,
   output logic [4:0]  BIT_CNT,
   output logic        READ_DONE
);

   logic        strb_s;
   logic        clk_s;
   logic        strb_q;
   logic        clk_q;
   logic        clk_rise;
   logic        strb_fall;
   logic [15:0] sr;
   logic        di0;
   logic [11:0] eff_buttons;

   // Synchroniser resets to the idle levels of the console lines.
   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign strb_s = JOY_STRB;
         assign clk_s  = JOY_CLK;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] strb_pipe;
         logic [SYNC_STAGES-1:0] clk_pipe;

         always_ff @(posedge MCLK or negedge RST_N) begin
            if (!RST_N) begin
               strb_pipe <= '0;
               clk_pipe  <= '1;
            end else begin
               strb_pipe[0] <= JOY_STRB;
               clk_pipe[0]  <= JOY_CLK;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  strb_pipe[i] <= strb_pipe[i-1];
                  clk_pipe[i]  <= clk_pipe[i-1];
               end
            end
         end

         assign strb_s = strb_pipe[SYNC_STAGES-1];
         assign clk_s  = clk_pipe[SYNC_STAGES-1];
      end
   endgenerate

   assign clk_rise  = clk_s & ~clk_q;
   assign strb_fall = ~strb_s & strb_q;

`ifdef SNES_JOYPAD_TURBO_EN
   localparam logic [3:0] TURBO_LAST = 4'(TURBO_PERIOD - 1);

   logic [3:0] turbo_cnt;
   logic       phase_on;

   always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
         turbo_cnt <= 4'd0;
         phase_on  <= 1'b1;
      end else if (strb_fall) begin
         if (turbo_cnt == TURBO_LAST) begin
            turbo_cnt <= 4'd0;
            phase_on  <= ~phase_on;
         end else begin
            turbo_cnt <= turbo_cnt + 4'd1;
         end
      end
   end

   assign eff_buttons = BUTTONS & ~(TURBO_MASK & {12{~phase_on}});
`else
   logic unused_turbo;
   assign unused_turbo = ^{TURBO_MASK, strb_fall};
   assign eff_buttons  = BUTTONS;
`endif

   // Latch dominates any clock edge; ones shift in so overclocked reads see "pressed".
   always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
         sr        <= 16'h0000;
         BIT_CNT   <= 5'd0;
         READ_DONE <= 1'b0;
         di0       <= 1'b1;
         strb_q    <= 1'b0;
         clk_q     <= 1'b1;
      end else begin
         strb_q    <= strb_s;
         clk_q     <= clk_s;
         READ_DONE <= 1'b0;
         di0       <= ~sr[0];
         if (strb_s) begin
            sr      <= {4'b0000, eff_buttons};
            BIT_CNT <= 5'd0;
         end else if (clk_rise) begin
            sr <= {1'b1, sr[15:1]};
            if (BIT_CNT != 5'd16) begin
               BIT_CNT <= BIT_CNT + 5'd1;
            end
            if (BIT_CNT == 5'd15) begin
               READ_DONE <= 1'b1;
            end
         end
      end
   end

   assign JOY_DI = {1'b1, di0};

endmodule

// File: tb/tb_snes_joypad.sv
// Self-checking bench for snes_joypad: vector table, hand-written corner sequences and random reads.
module tb_snes_joypad;

   localparam int TP = 2;

   logic        MCLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        JOY_STRB = 1'b0;
   logic        JOY_CLK = 1'b1;
   logic [11:0] BUTTONS = 12'h000;
   logic [11:0] TURBO_MASK = 12'h000;
   logic [1:0]  JOY_DI;
   logic [4:0]  BIT_CNT;
   logic        READ_DONE;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   typedef struct {
      logic [11:0] buttons;
      int          nclk;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs[6];

   snes_joypad #(
      .SYNC_STAGES (0),
      .TURBO_PERIOD(TP)
   ) dut (
      .MCLK      (MCLK),
      .RST_N     (RST_N),
      .JOY_STRB  (JOY_STRB),
      .JOY_CLK   (JOY_CLK),
      .BUTTONS   (BUTTONS),
      .TURBO_MASK(TURBO_MASK),
      .JOY_DI    (JOY_DI),
      .BIT_CNT   (BIT_CNT),
      .READ_DONE (READ_DONE)
   );

   always #5 MCLK = ~MCLK;

   always @(negedge MCLK) begin
      if (READ_DONE === 1'b1) done_cnt++;
   end

   initial begin
      #10ms;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: act=%0h req=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge MCLK);
         #1;
      end
   endtask

   task automatic strobe(input int hold);
      JOY_STRB = 1'b1;
      tick(hold);
      JOY_STRB = 1'b0;
      tick(3);
   endtask

   task automatic clk_pulse();
      JOY_CLK = 1'b0;
      tick(3);
      JOY_CLK = 1'b1;
      tick(3);
   endtask

   // Shift from bit n_from to n_to, checking the serial line against the expected stream.
   task automatic shift_check(input logic [15:0] exp_word, input int n_from, input int n_to,
                              input string tag);
      logic exp_bit;
      for (int n = n_from; n <= n_to; n++) begin
         clk_pulse();
         exp_bit = (n < 16) ? exp_word[n] : 1'b0;
         check($sformatf("%s di n=%0d", tag, n), 32'(JOY_DI), {30'd0, 1'b1, exp_bit});
         check($sformatf("%s cnt n=%0d", tag, n), 32'(BIT_CNT), 32'((n > 16) ? 16 : n));
      end
   endtask

   task automatic do_read(input logic [11:0] btn, input int nclk, input logic [15:0] exp_word,
                          input logic [11:0] late_btn, input string tag);
      int d0;
      BUTTONS = btn;
      strobe(12);
      BUTTONS = late_btn;
      d0 = done_cnt;
      check({tag, " bit0"}, 32'(JOY_DI), {30'd0, 1'b1, exp_word[0]});
      check({tag, " cnt0"}, 32'(BIT_CNT), 32'd0);
      shift_check(exp_word, 1, nclk, tag);
      check({tag, " done"}, 32'(done_cnt - d0), 32'((nclk >= 16) ? 1 : 0));
   endtask

   function automatic logic [15:0] model_word(input logic [11:0] btn);
      return ~{4'b0000, btn};
   endfunction

   initial begin
      logic [11:0] rb;
      logic [11:0] lb;
      int          rn;
      logic        pressed;

      vecs[0] = '{12'h001, 16, 16'hFFFE};
      vecs[1] = '{12'hA5C, 16, 16'hF5A3};
      vecs[2] = '{12'h000, 20, 16'hFFFF};
      vecs[3] = '{12'hFFF, 18, 16'hF000};
      vecs[4] = '{12'h800, 12, 16'hF7FF};
      vecs[5] = '{12'h3C3, 15, 16'hFC3C};

      // Reset with all buttons held.
      BUTTONS = 12'hFFF;
      tick(4);
      check("rst di", 32'(JOY_DI), 32'd3);
      check("rst cnt", 32'(BIT_CNT), 32'd0);
      check("rst done", 32'(READ_DONE), 32'd0);
      RST_N = 1'b1;
      tick(5);
      check("post rst di", 32'(JOY_DI), 32'd3);
      check("post rst cnt", 32'(BIT_CNT), 32'd0);
      check("post rst done", 32'(done_cnt), 32'd0);

      foreach (vecs[i]) begin
         do_read(vecs[i].buttons, vecs[i].nclk, vecs[i].exp_word, vecs[i].buttons,
                 $sformatf("vec%0d", i));
      end

      // Restart after 5 clocks.
      do_read(12'h3C3, 5, 16'hFC3C, 12'h3C3, "pre-restart");
      do_read(12'h3C3, 16, 16'hFC3C, 12'h3C3, "restart");

      // Latch priority over a clock rise during strobe.
      JOY_CLK = 1'b0;
      tick(3);
      BUTTONS = 12'h800;
      JOY_STRB = 1'b1;
      tick(3);
      JOY_CLK = 1'b1;
      tick(3);
      check("prio cnt hi", 32'(BIT_CNT), 32'd0);
      check("prio di hi", 32'(JOY_DI), 32'd3);
      JOY_STRB = 1'b0;
      tick(3);
      check("prio cnt lo", 32'(BIT_CNT), 32'd0);
      check("prio di lo", 32'(JOY_DI), 32'd3);
      shift_check(16'hF7FF, 1, 11, "prio");

      // Buttons changing mid-shift are ignored.
      do_read(12'h0F0, 16, 16'hFF0F, 12'hF0F, "late btn");

      // Reset mid-read.
      do_read(12'hFFF, 5, 16'hF000, 12'hFFF, "pre-rst");
      RST_N = 1'b0;
      #1;
      check("midrst di", 32'(JOY_DI), 32'd3);
      check("midrst cnt", 32'(BIT_CNT), 32'd0);
      check("midrst done", 32'(READ_DONE), 32'd0);
      tick(2);
      RST_N = 1'b1;
      tick(3);
      check("midrst after di", 32'(JOY_DI), 32'd3);

      // Random reads with random late button changes.
      for (int k = 0; k < 20; k++) begin
         rb = 12'($urandom);
         lb = 12'($urandom);
         rn = $urandom_range(20, 0);
         do_read(rb, rn, model_word(rb), lb, $sformatf("rnd%0d", k));
      end

      // Autofire: fresh reset so the latch count starts from zero.
      RST_N = 1'b0;
      tick(2);
      RST_N = 1'b1;
      tick(2);
      TURBO_MASK = 12'h100;
      for (int k = 0; k < 6; k++) begin
`ifdef SNES_JOYPAD_TURBO_EN
         pressed = ((k / TP) % 2) == 0;
`else
         pressed = 1'b1;
`endif
         do_read(12'h100, 9, model_word(pressed ? 12'h100 : 12'h000), 12'h100,
                 $sformatf("turbo%0d", k));
      end
      TURBO_MASK = 12'h000;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/snes_joypad.md
Name: snes_joypad

Overview:
- Controller-side responder for the SNES serial joypad port.
- Emulates a standard 12-button pad, driven by the console's JOY_STRB (latch) and JOY1_CLK/JOY2_CLK (per-port clock).
- Presents the active-low serial data bits that the console samples on JOY1_DI/JOY2_DI.
- Sits between the host input logic (USB/gamepad decoder) and the SNES core; one instance per port.

Parameters:
- SYNC_STAGES, 0, number of MCLK synchroniser flops on JOY_STRB/JOY_CLK. Use 0 when the inputs come from the same MCLK domain; use 2 when they are sourced externally.
- TURBO_PERIOD, 4, number of latch falling edges per turbo phase. Legal range 1..15.

Ports:
- MCLK  in  1  master clock, 21 MHz; all state is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- JOY_STRB  in  1  latch from console, active high.
- JOY_CLK  in  1  serial clock from console; idles high, data advances on its rising edge.
- BUTTONS  in  12  1 = pressed. Order bit0..11: B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R.
- TURBO_MASK  in  12  1 = button is autofired. Ignored unless SNES_JOYPAD_TURBO_EN is defined.
- JOY_DI  out  2  [0] serial data (0 = pressed/one), [1] multitap line, constant 1.
- BIT_CNT  out  5  number of bits shifted since latch, 0..16, saturating.
- READ_DONE  out  1  one-MCLK pulse when the 16th shift occurs.

Behaviour:
- Reset (async, RST_N=0) sets:
  - shift register to 16'h0000, so JOY_DI=2'b11;
  - BIT_CNT=0, READ_DONE=0;
  - edge-detect history to strb_q=0, clk_q=1;
  - turbo counter=0, turbo phase=on.
- Input conditioning:
  - JOY_STRB and JOY_CLK pass through SYNC_STAGES flops (0 = direct).
  - The conditioned values are registered once more (strb_q, clk_q) for edge detection.
  - clk_rise = clk & ~clk_q; strb_fall = ~strb & strb_q.
- Shift register sr[15:0], logic 1 = pressed:
  - Load value = {4'b0000, eff_buttons[11:0]}; sr[0] is the first bit out (B).
  - eff_buttons = BUTTONS with turbo applied (see Optional Feature); otherwise BUTTONS.
- Per MCLK, in priority order:
  1. JOY_STRB high (conditioned): sr loaded every cycle (transparent latch), BIT_CNT=0. Clock edges are ignored; latch dominates a simultaneous clock edge.
  2. Else, on clk_rise:
     - sr = {1'b1, sr[15:1]}; ones shift in, so after 16 shifts the line reads "pressed", matching official pads.
     - BIT_CNT = min(BIT_CNT+1, 16).
     - READ_DONE=1 for one cycle when BIT_CNT goes 15 -> 16.
  3. Else: hold.
- Output mapping:
  - JOY_DI[0] = ~sr[0], registered; it reflects the new sr one MCLK after the load/shift cycle.
  - JOY_DI[1] = 1 always.
- Latency: a console edge reaches JOY_DI in SYNC_STAGES+2 MCLK cycles. With SYNC_STAGES=0 that is ≤ 0.1 us, well inside the console's ~6 us bit period.
- Boundaries:
  - Clocks beyond 16 keep JOY_DI[0]=0; BIT_CNT stays 16 and READ_DONE does not re-fire.
  - A latch pulse in mid-read restarts the sequence at bit 0.
  - A BUTTONS change during shifting has no effect until the next latch.
  - Reset mid-read returns the block to its reset state immediately.

Optional Feature:
- Macro: SNES_JOYPAD_TURBO_EN.
- When defined:
  - A 4-bit counter increments on each strb_fall.
  - When the counter reaches TURBO_PERIOD-1 it wraps to 0 and the turbo phase toggles.
  - eff_buttons = BUTTONS & ~(TURBO_MASK & {12{~phase_on}}).
  - The counter and phase are reset by RST_N.
- When undefined:
  - eff_buttons = BUTTONS; TURBO_MASK is unused.
  - No counter or phase logic is synthesised.

Test Plan:
- Reset: hold RST_N=0 with BUTTONS=12'hFFF -> JOY_DI=2'b11, BIT_CNT=0, READ_DONE=0; stays so after release with no strobe.
- Full read, BUTTONS=12'h001 (B): strobe high 12 cycles, low, then 16 JOY_CLK pulses.
  - Bit 0 (before the first rise) reads JOY_DI[0]=0.
  - Bits 1..15 read 1.
  - READ_DONE pulses once at the 16th rise; BIT_CNT=16.
- Pattern BUTTONS=12'hA5C, strobe then 16 clocks -> sampled JOY_DI[0] sequence equals ~{4'b0000,12'hA5C} LSB-first.
- Overclock and restart:
  - BUTTONS=12'h000, 20 clocks -> bits 16..19 read 0, READ_DONE fires once.
  - Strobe after the 5th clock -> bit 0 presented again, BIT_CNT=0.
- Latch priority: JOY_CLK rising in the same cycle JOY_STRB is high, BUTTONS=12'h800 -> no shift; after strobe falls, bit 11 (R) appears at the 11th rise.
- Turbo (macro on, TURBO_PERIOD=2, TURBO_MASK=12'h100, A held):
  - Successive latches read A as pressed, pressed, released, released, pressed, ...
  - Macro off: A reads pressed on every latch.
